// File: rtl/fft_frame_sequencer_if.sv
// Stream bundle for fft_frame_sequencer: sample input (s_*) and result output (m_*).
// master = streaming fabric side, slave = the sequencer.
interface fft_frame_sequencer_if #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 64
);
  logic                 s_valid;
  logic                 s_ready;
  logic [IN_WIDTH-1:0]  s_data;
  logic                 s_last;
  logic                 m_valid;
  logic                 m_ready;
  logic [OUT_WIDTH-1:0] m_data;
  logic                 m_last;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_last
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_last
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame controller for the shared-butterfly FFT core: LOAD -> CALC -> UNLOAD with a skid-buffered output.
// Define FFT_SEQ_BITREV_EN to read the result RAM in bit-reversed order (natural-order output).
module fft_frame_sequencer #(
  parameter int N          = 8192,
  parameter int ADDR_WIDTH = $clog2(N),
  parameter int IN_WIDTH   = 16,
  parameter int OUT_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  fft_frame_sequencer_if.slave  stream,
  output logic                  core_en,
  output logic [1:0]            core_mode,
  output logic [IN_WIDTH-1:0]   core_x_in,
  input  logic                  core_done,
  output logic [ADDR_WIDTH-1:0] unl_addr,
  input  logic [OUT_WIDTH-1:0]  core_dout,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_last
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);
  localparam logic [1:0] MODE_IDLE  = 2'd0;
  localparam logic [1:0] MODE_CALC  = 2'd1;
  localparam logic [1:0] MODE_WRITE = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CALC, ST_UNLOAD} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] load_cnt_reg;
  logic [ADDR_WIDTH-1:0] rd_cnt_reg;
  logic [ADDR_WIDTH-1:0] addr_order;
  logic                  issued_all_reg;
  logic                  inflight_reg;
  logic                  inflight_last_reg;
  logic [1:0]            fifo_cnt_reg;
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;
  logic [OUT_WIDTH-1:0]  ent_data [2];
  logic                  ent_last [2];
  logic                  frame_done_reg;
  logic                  err_last_reg;

  logic                  s_ready_int;
  logic                  s_xfer;
  logic                  m_valid_int;
  logic                  head_last;
  logic                  pop;
  logic                  issue;
  logic [2:0]            slots_used;

  // ---------------- FSM next-state and core controls ----------------
  always_comb begin
    state_next  = state_reg;
    s_ready_int = 1'b0;
    core_en     = 1'b0;
    core_mode   = MODE_IDLE;
    core_x_in   = '0;
    case (state_reg)
      ST_IDLE: begin
        if (start) state_next = ST_LOAD;
      end
      ST_LOAD: begin
        s_ready_int = 1'b1;
        core_mode   = MODE_WRITE;
        core_en     = stream.s_valid & s_ready_int;
        core_x_in   = stream.s_data;
        if (stream.s_valid && load_cnt_reg == LAST_IDX) state_next = ST_CALC;
      end
      ST_CALC: begin
        core_mode = MODE_CALC;
        core_en   = 1'b1;
        if (core_done) state_next = ST_UNLOAD;
      end
      ST_UNLOAD: begin
        if (pop && head_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign s_xfer      = stream.s_valid & s_ready_int;
  assign m_valid_int = (fifo_cnt_reg != 2'd0);
  assign head_last   = ent_last[rd_ptr_reg];
  assign pop         = m_valid_int & stream.m_ready;

  // The slot freed by this cycle's pop counts, so 1 beat/cycle is sustained with 2 entries.
  assign slots_used = {1'b0, fifo_cnt_reg} + {2'b00, inflight_reg};
  assign issue      = (state_reg == ST_UNLOAD) && !issued_all_reg &&
                      (slots_used < (3'd2 + {2'b00, pop}));

`ifdef FFT_SEQ_BITREV_EN
  genvar gi;
  generate
    for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_bitrev
      assign addr_order[gi] = rd_cnt_reg[ADDR_WIDTH-1-gi];
    end
  endgenerate
`else
  genvar gi;
  assign addr_order = rd_cnt_reg;
`endif

  assign unl_addr = (state_reg == ST_UNLOAD) ? addr_order : '0;

  // ---------------- state, counters, flags ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      load_cnt_reg      <= '0;
      rd_cnt_reg        <= '0;
      issued_all_reg    <= 1'b0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
      fifo_cnt_reg      <= 2'd0;
      wr_ptr_reg        <= 1'b0;
      rd_ptr_reg        <= 1'b0;
      frame_done_reg    <= 1'b0;
      err_last_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      frame_done_reg <= pop & head_last;

      if (s_xfer) begin
        load_cnt_reg <= load_cnt_reg + 1'b1;
        if (stream.s_last != (load_cnt_reg == LAST_IDX)) err_last_reg <= 1'b1;
      end

      if (state_reg == ST_IDLE) begin
        rd_cnt_reg     <= '0;
        issued_all_reg <= 1'b0;
      end else if (issue) begin
        rd_cnt_reg <= rd_cnt_reg + 1'b1;
        if (rd_cnt_reg == LAST_IDX) issued_all_reg <= 1'b1;
      end

      // RAM read data lands one cycle after the address is issued.
      inflight_reg      <= issue;
      inflight_last_reg <= issue && (rd_cnt_reg == LAST_IDX);

      if (inflight_reg) wr_ptr_reg <= ~wr_ptr_reg;
      if (pop)          rd_ptr_reg <= ~rd_ptr_reg;
      fifo_cnt_reg <= fifo_cnt_reg + {1'b0, inflight_reg} - {1'b0, pop};
    end
  end

  // ---------------- 2-entry skid FIFO storage ----------------
  generate
    for (gi = 0; gi < 2; gi++) begin : g_skid
      logic [OUT_WIDTH-1:0] data_reg;
      logic                 last_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          data_reg <= '0;
          last_reg <= 1'b0;
        end else if (inflight_reg && (wr_ptr_reg == 1'(gi))) begin
          data_reg <= core_dout;
          last_reg <= inflight_last_reg;
        end
      end
      assign ent_data[gi] = data_reg;
      assign ent_last[gi] = last_reg;
    end
  endgenerate

  assign stream.s_ready = s_ready_int;
  assign stream.m_valid = m_valid_int;
  assign stream.m_data  = m_valid_int ? ent_data[rd_ptr_reg] : '0;
  assign stream.m_last  = m_valid_int & head_last;

  assign busy       = (state_reg != ST_IDLE);
  assign frame_done = frame_done_reg;
  assign err_last   = err_last_reg;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer (N=16): scoreboard of expected result beats,
// a behavioural core (done after 6 CALC cycles) and a result RAM with 1-cycle read latency.
module tb_fft_frame_sequencer;
  localparam int N  = 16;
  localparam int AW = 4;
  localparam int IW = 16;
  localparam int OW = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          core_en;
  logic [1:0]    core_mode;
  logic [IW-1:0] core_x_in;
  logic          core_done;
  logic [AW-1:0] unl_addr;
  logic [OW-1:0] core_dout = '0;
  logic          busy;
  logic          frame_done;
  logic          err_last;

  fft_frame_sequencer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

  fft_frame_sequencer #(.N(N), .ADDR_WIDTH(AW), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stream     (bus.slave),
    .core_en    (core_en),
    .core_mode  (core_mode),
    .core_x_in  (core_x_in),
    .core_done  (core_done),
    .unl_addr   (unl_addr),
    .core_dout  (core_dout),
    .busy       (busy),
    .frame_done (frame_done),
    .err_last   (err_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int calc_cnt = 0;
  logic [64:0] sb_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_addr(input int k);
    logic [AW-1:0] a;
    logic [AW-1:0] r;
    a = AW'(k);
    r = a;
`ifdef FFT_SEQ_BITREV_EN
    for (int b = 0; b < AW; b++) r[b] = a[AW-1-b];
`endif
    return r;
  endfunction

  function automatic logic [63:0] pat(input logic [AW-1:0] a);
    return {32'hC0DE_0000 | {28'h0, a}, 32'h0BEE_F000 ^ {24'h0, a, 4'h5}};
  endfunction

  // Core model: done pulse on the 6th CALC cycle; RAM returns pat(addr) one cycle later.
  always @(posedge clk) begin
    if (rst || core_mode != 2'd1) calc_cnt <= 0;
    else                          calc_cnt <= calc_cnt + 1;
    core_dout <= pat(unl_addr);
  end
  assign core_done = (core_mode == 2'd1) && (calc_cnt == 5);

  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) < 30);
    end
  end

  // Monitor: scoreboard pops, hold-while-stalled, core_en == transfer in LOAD.
  logic        stall_prev = 1'b0;
  logic [63:0] held_data = '0;
  logic [64:0] exp_beat;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 64'(bus.m_valid), 64'(1));
        chk("hold_data", bus.m_data, held_data);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 64'(sb_q.size()), 64'(1));
        end else begin
          exp_beat = sb_q.pop_front();
          chk("m_data", bus.m_data, exp_beat[63:0]);
          chk("m_last", 64'(bus.m_last), 64'(exp_beat[64]));
          beats++;
          $display("beat %0d data=%016h last=%0b", beats, bus.m_data, bus.m_last);
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      held_data  = bus.m_data;
      if (core_mode == 2'd2) begin
        chk("en_eq_xfer", 64'(core_en), 64'(bus.s_valid && bus.s_ready));
        if (core_en) begin
          chk("core_x_in", 64'(core_x_in), 64'(bus.s_data));
          en_cnt++;
        end
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, 64'(bus.s_ready), 64'(0));
    chk({tag, "_core_en"}, 64'(core_en), 64'(0));
    chk({tag, "_core_mode"}, 64'(core_mode), 64'(0));
    chk({tag, "_core_x_in"}, 64'(core_x_in), 64'(0));
    chk({tag, "_unl_addr"}, 64'(unl_addr), 64'(0));
    chk({tag, "_m_valid"}, 64'(bus.m_valid), 64'(0));
    chk({tag, "_m_data"}, bus.m_data, 64'(0));
    chk({tag, "_m_last"}, 64'(bus.m_last), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_frame_done"}, 64'(frame_done), 64'(0));
    chk({tag, "_err_last"}, 64'(err_last), 64'(0));
  endtask

  // Called at posedge+1 in IDLE; leaves the DUT in LOAD at posedge+1.
  task automatic start_frame();
    for (int k = 0; k < N; k++) sb_q.push_back({(k == N - 1), pat(exp_addr(k))});
    beats  = 0;
    en_cnt = 0;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("load_busy", 64'(busy), 64'(1));
    chk("load_s_ready", 64'(bus.s_ready), 64'(1));
    chk("load_mode", 64'(core_mode), 64'(2));
  endtask

  task automatic load_frame(input bit toggle, input int last_pos, input bit exp_err);
    int i = 0;
    int cyc = 0;
    while (i < N && cyc < 200) begin
      bus.s_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      bus.s_data  = IW'(i);
      bus.s_last  = (i == last_pos);
      @(negedge clk);
      if (bus.s_valid && bus.s_ready) i++;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    chk("load_samples", 64'(i), 64'(N));
    chk("load_core_en_pulses", 64'(en_cnt), 64'(N));
    chk("calc_entered", 64'(core_mode), 64'(1));
    chk("calc_s_ready", 64'(bus.s_ready), 64'(0));
    chk("err_last_after_load", 64'(err_last), 64'(exp_err));
    $display("load done: transfers=%0d core_en=%0d cycles=%0d err_last=%0b", i, en_cnt, cyc, err_last);
  endtask

  // Ends at posedge+1 of the first UNLOAD cycle.
  task automatic wait_calc(input bit poke_start);
    int cyc = 0;
    if (poke_start) start = 1'b1;
    while (1) begin
      @(negedge clk);
      chk("calc_mode", 64'(core_mode), 64'(1));
      chk("calc_en", 64'(core_en), 64'(1));
      if (core_done) break;
      cyc++;
      if (cyc > 100) begin
        chk("core_done_timeout", 64'(core_done), 64'(1));
        break;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("unload_mode", 64'(core_mode), 64'(0));
    chk("unload_en", 64'(core_en), 64'(0));
  endtask

  task automatic finish_frame(input bit exp_err);
    int cyc = 0;
    int done_before = done_cnt;
    while (1) begin
      @(negedge clk);
      if (frame_done) break;
      cyc++;
      if (cyc > 400) begin
        chk("frame_done_timeout", 64'(frame_done), 64'(1));
        break;
      end
    end
    chk("done_idle", 64'(busy), 64'(0));
    chk("beats_out", 64'(beats), 64'(N));
    chk("sb_empty", 64'(sb_q.size()), 64'(0));
    chk("err_last_end", 64'(err_last), 64'(exp_err));
    @(posedge clk);
    #1;
    chk("frame_done_pulse", 64'(frame_done), 64'(0));
    chk("frame_done_count", 64'(done_cnt - done_before), 64'(1));
    $display("frame done: beats=%0d unload_cycles=%0d err_last=%0b", beats, cyc, err_last);
  endtask

  initial begin
    int cyc;
    int done_snap;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: back-to-back frame, full throughput unload with latency checks
    start_frame();
    load_frame(1'b0, N - 1, 1'b0);
    wait_calc(1'b0);
    chk("u0_addr", 64'(unl_addr), 64'(exp_addr(0)));
    chk("u0_m_valid", 64'(bus.m_valid), 64'(0));
    @(posedge clk);
    #1;
    chk("u1_addr", 64'(unl_addr), 64'(exp_addr(1)));
    chk("u1_m_valid", 64'(bus.m_valid), 64'(0));
    @(posedge clk);
    #1;
    chk("u2_addr", 64'(unl_addr), 64'(exp_addr(2)));
    chk("u2_m_valid", 64'(bus.m_valid), 64'(1));
    finish_frame(1'b0);

    // 2: toggling s_valid, start poked during CALC is ignored
    start_frame();
    load_frame(1'b1, N - 1, 1'b0);
    wait_calc(1'b1);
    finish_frame(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("no_restart", 64'(busy), 64'(0));

    // 3: 30% random m_ready backpressure
    ready_mode = 1;
    start_frame();
    load_frame(1'b0, N - 1, 1'b0);
    wait_calc(1'b0);
    finish_frame(1'b0);
    ready_mode = 0;

    // 4: misplaced s_last on sample 8
    start_frame();
    load_frame(1'b0, 8, 1'b1);
    wait_calc(1'b0);
    finish_frame(1'b1);

    // 5: reset mid-UNLOAD after beat 5, then a full clean frame
    start_frame();
    load_frame(1'b0, N - 1, 1'b1);
    wait_calc(1'b0);
    cyc = 0;
    while (beats < 5 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("beats_before_reset", 64'(beats), 64'(5));
    done_snap = done_cnt;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("midrst");
    rst = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    chk("no_done_on_abort", 64'(done_cnt), 64'(done_snap));
    start_frame();
    load_frame(1'b0, N - 1, 1'b0);
    wait_calc(1'b0);
    finish_frame(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
